// File: rtl/keymem_pkg.sv
// Shared definitions for the key-memory arbiter: state encoding and key/id widths.
package keymem_pkg;

  localparam int KEY_W = 256;
  localparam int ID_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } km_state_t;

  // Index width for a requester vector; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: searches upward from last_grant+1, wrapping at NUM_REQ.
module rr_arbiter
  import keymem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/keymem_arbiter.sv
// Arbitrates NUM_REQ key requesters onto the single keymem_top request port,
// with a per-transaction ack timeout and a saturating abort counter.
module keymem_arbiter
  import keymem_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                    key_clk,
  input  logic                    key_aresetn,
  input  logic [NUM_REQ-1:0]      req_key_req,
  input  logic [NUM_REQ*ID_W-1:0] req_key_id,
  output logic [NUM_REQ-1:0]      req_key_ack,
  output logic                    req_key_err,
  output logic [KEY_W-1:0]        req_key,
  output logic                    mem_key_req,
  output logic [ID_W-1:0]         mem_key_id,
  input  logic                    mem_key_ack,
  input  logic [KEY_W-1:0]        mem_key,
  output logic [15:0]             timeout_count
);

  localparam int IDX_W = idx_width(NUM_REQ);

  km_state_t          state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [15:0]        tmo_cnt;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_key_req),
    .last_grant (last_grant),
    .grant      (arb_oh),
    .grant_idx  (arb_idx),
    .grant_vld  (arb_vld)
  );

  always_ff @(posedge key_clk or negedge key_aresetn) begin
    if (!key_aresetn) begin
      state         <= ST_IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      grant_idx     <= '0;
      grant_oh      <= '0;
      tmo_cnt       <= '0;
      timeout_count <= '0;
      mem_key_req   <= 1'b0;
      mem_key_id    <= '0;
      req_key_ack   <= '0;
      req_key_err   <= 1'b0;
      req_key       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            grant_idx   <= arb_idx;
            grant_oh    <= arb_oh;
            last_grant  <= arb_idx;
            mem_key_id  <= req_key_id[arb_idx*ID_W +: ID_W];
            mem_key_req <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack arriving on the final timeout cycle still completes cleanly.
          if (mem_key_ack) begin
            req_key     <= mem_key;
            req_key_err <= 1'b0;
            req_key_ack <= grant_oh;
            mem_key_req <= 1'b0;
            mem_key_id  <= '0;
            state       <= ST_RESP;
          end else if (tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
            req_key       <= '0;
            req_key_err   <= 1'b1;
            req_key_ack   <= grant_oh;
            timeout_count <= sat_inc(timeout_count);
            mem_key_req   <= 1'b0;
            mem_key_id    <= '0;
            state         <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          // Key material is wiped after its single ack cycle.
          req_key_ack <= '0;
          req_key     <= '0;
          req_key_err <= 1'b0;
          state       <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!req_key_req[grant_idx]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keymem_arbiter.sv
// Scoreboard bench for keymem_arbiter: directed requester/keymem scenarios,
// expected grants and responses queued at issue and checked by a monitor thread.
module tb_keymem_arbiter;

  localparam int NREQ = 4;

  logic              key_clk = 1'b0;
  logic              key_aresetn;
  logic [NREQ-1:0]   req_key_req;
  logic [NREQ*32-1:0] req_key_id;
  logic [NREQ-1:0]   req_key_ack;
  logic              req_key_err;
  logic [255:0]      req_key;
  logic              mem_key_req;
  logic [31:0]       mem_key_id;
  logic              mem_key_ack;
  logic [255:0]      mem_key;
  logic [15:0]       timeout_count;

  keymem_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (16'd1024)
  ) dut (
    .key_clk       (key_clk),
    .key_aresetn   (key_aresetn),
    .req_key_req   (req_key_req),
    .req_key_id    (req_key_id),
    .req_key_ack   (req_key_ack),
    .req_key_err   (req_key_err),
    .req_key       (req_key),
    .mem_key_req   (mem_key_req),
    .mem_key_id    (mem_key_id),
    .mem_key_ack   (mem_key_ack),
    .mem_key       (mem_key),
    .timeout_count (timeout_count)
  );

  always #5 key_clk = ~key_clk;

  typedef struct packed {
    logic [3:0]   ack;
    logic         err;
    logic [255:0] key;
    logic [15:0]  tcnt;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] id_q[$];

  int n_chk;
  int n_fail;

  // keymem model and requester behaviour
  int           mem_delay;
  logic [255:0] mem_cfg_key;
  bit           key_from_id;
  int           mem_wait;
  bit           late_ack;
  int           hold_cfg[NREQ];
  int           hold_tmr[NREQ];
  int           rearm_tmr[NREQ];
  int           rearm_left[NREQ];
  int           cyc_no;
  int           ack_cyc[NREQ];
  int           mreq_rise_cyc;
  logic         stim_prev_mreq;
  int           req_cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic [31:0] id, input logic [3:0] ack, input logic err,
                            input logic [255:0] key, input logic [15:0] tcnt);
    resp_t r;
    r.ack = ack; r.err = err; r.key = key; r.tcnt = tcnt;
    id_q.push_back(id);
    resp_q.push_back(r);
  endtask

  task automatic drop_req(input int i);
    req_key_req[i] = 1'b0;
    if (rearm_left[i] > 0) begin
      rearm_left[i]--;
      rearm_tmr[i] = 2;
    end
  endtask

  task automatic cyc();
    @(negedge key_clk);
    cyc_no++;
    mem_key_ack = 1'b0;
    mem_key     = '0;
    if (late_ack) begin
      mem_key_ack = 1'b1;
      mem_key     = {32{8'hEE}};
      late_ack    = 1'b0;
    end else if (mem_key_req) begin
      if (mem_wait == mem_delay) begin
        mem_key_ack = 1'b1;
        mem_key     = key_from_id ? {8{mem_key_id}} : mem_cfg_key;
      end
      mem_wait++;
    end else begin
      mem_wait = 0;
    end
    if (mem_key_req && !stim_prev_mreq) mreq_rise_cyc = cyc_no;
    stim_prev_mreq = mem_key_req;
    for (int i = 0; i < NREQ; i++) begin
      if (rearm_tmr[i] > 0) begin
        rearm_tmr[i]--;
        if (rearm_tmr[i] == 0) req_key_req[i] = 1'b1;
      end
      if (hold_tmr[i] > 0) begin
        hold_tmr[i]--;
        if (hold_tmr[i] == 0) drop_req(i);
      end
      if (req_key_ack[i]) begin
        ack_cyc[i] = cyc_no;
        if (hold_cfg[i] == 0) drop_req(i);
        else hold_tmr[i] = hold_cfg[i];
      end
    end
  endtask

  task automatic run_until_empty(input int bound, input string name);
    int n = 0;
    while ((resp_q.size() != 0 || req_key_req != '0) && n < bound) begin
      cyc();
      n++;
    end
    if (resp_q.size() != 0 || req_key_req != '0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: not complete after %0d cycles, %0d responses outstanding", name, bound, resp_q.size());
    end
    repeat (3) cyc();
  endtask

  task automatic wait_mreq(input int bound, input string name);
    int n = 0;
    while (!mem_key_req && n < bound) begin
      cyc();
      n++;
    end
    if (!mem_key_req) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: mem_key_req not seen within %0d cycles, got 0 expected 1", name, bound);
    end
  endtask

  task automatic monitor();
    logic  prev = 1'b0;
    resp_t e;
    forever begin
      @(negedge key_clk);
      if (!key_aresetn) begin
        prev = 1'b0;
      end else begin
        chk("ack_onehot0", 256'($onehot0(req_key_ack)), 256'd1);
        if (req_key_ack == '0) chk("key_zero_without_ack", {req_key_err, req_key[254:0]}, '0);
        if (mem_key_req && !prev) begin
          if (id_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_mem_req: got id %h expected no request", mem_key_id);
          end else begin
            chk("mem_key_id", mem_key_id, id_q.pop_front());
          end
        end
        prev = mem_key_req;
        if (req_key_ack != '0) begin
          if (resp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack %b expected none", req_key_ack);
          end else begin
            e = resp_q.pop_front();
            chk("req_key_ack", req_key_ack, e.ack);
            chk("req_key_err", req_key_err, e.err);
            chk("req_key", req_key, e.key);
            chk("timeout_count", timeout_count, e.tcnt);
          end
        end
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    key_aresetn = 1'b0;
    req_key_req = '0; req_key_id = '0;
    mem_key_ack = 1'b0; mem_key = '0;
    mem_delay = -1; mem_cfg_key = '0; key_from_id = 1'b0; mem_wait = 0; late_ack = 1'b0;
    cyc_no = 0; mreq_rise_cyc = 0; stim_prev_mreq = 1'b0; req_cyc = 0;
    for (int i = 0; i < NREQ; i++) begin
      hold_cfg[i] = 0; hold_tmr[i] = 0; rearm_tmr[i] = 0; rearm_left[i] = 0; ack_cyc[i] = 0;
    end

    fork
      monitor();
    join_none

    // reset state
    repeat (3) cyc();
    chk("rst_mem_key_req", mem_key_req, 0);
    chk("rst_mem_key_id", mem_key_id, 0);
    chk("rst_req_key_ack", req_key_ack, 0);
    chk("rst_req_key_err", req_key_err, 0);
    chk("rst_req_key", req_key, 0);
    chk("rst_timeout_count", timeout_count, 0);
    key_aresetn = 1'b1;
    cyc();

    // single request, keymem acks three cycles after the request appears
    mem_delay = 3; key_from_id = 1'b0; mem_cfg_key = {32{8'hA5}};
    expect_txn(32'h5, 4'b0001, 1'b0, {32{8'hA5}}, 16'd0);
    req_key_id[31:0] = 32'h5;
    req_key_req[0] = 1'b1;
    req_cyc = cyc_no;
    run_until_empty(50, "single_req");
    chk("lat_req_to_memreq", 32'(mreq_rise_cyc - req_cyc), 32'd1);
    chk("lat_memreq_to_ack", 32'(ack_cyc[0] - mreq_rise_cyc), 32'd4);

    // fresh reset so requester 0 is first in line, then all four compete
    key_aresetn = 1'b0;
    cyc();
    key_aresetn = 1'b1;
    cyc();
    req_key_id = {32'h103, 32'h102, 32'h101, 32'h100};
    mem_delay = 1; key_from_id = 1'b1;
    rearm_left[0] = 1;
    expect_txn(32'h100, 4'b0001, 1'b0, {8{32'h100}}, 16'd0);
    expect_txn(32'h101, 4'b0010, 1'b0, {8{32'h101}}, 16'd0);
    expect_txn(32'h102, 4'b0100, 1'b0, {8{32'h102}}, 16'd0);
    expect_txn(32'h103, 4'b1000, 1'b0, {8{32'h103}}, 16'd0);
    expect_txn(32'h100, 4'b0001, 1'b0, {8{32'h100}}, 16'd0);
    req_key_req = 4'b1111;
    run_until_empty(300, "round_robin");

    // no keymem ack: timeout abort, then a late ack that must be ignored
    mem_delay = -1;
    req_key_id[63:32] = 32'h77;
    expect_txn(32'h77, 4'b0010, 1'b1, '0, 16'd1);
    req_key_req[1] = 1'b1;
    run_until_empty(1200, "timeout");
    chk("timeout_latency", 32'(ack_cyc[1] - mreq_rise_cyc), 32'd1024);
    late_ack = 1'b1;
    repeat (5) cyc();
    chk("late_ack_tcount", timeout_count, 16'd1);
    chk("late_ack_no_memreq", mem_key_req, 0);

    // ack on the last timeout cycle wins
    mem_delay = 1023; key_from_id = 1'b0; mem_cfg_key = {32{8'h3C}};
    req_key_id[95:64] = 32'h99;
    expect_txn(32'h99, 4'b0100, 1'b0, {32{8'h3C}}, 16'd1);
    req_key_req[2] = 1'b1;
    run_until_empty(1200, "ack_on_timeout_cycle");
    chk("edge_ack_latency", 32'(ack_cyc[2] - mreq_rise_cyc), 32'd1024);
    chk("edge_ack_tcount", timeout_count, 16'd1);

    // requester 2 holds its request 5 cycles after ack; requester 3 waits
    mem_delay = 0; key_from_id = 1'b1;
    hold_cfg[2] = 5;
    req_key_id[95:64]  = 32'h22;
    req_key_id[127:96] = 32'h33;
    expect_txn(32'h22, 4'b0100, 1'b0, {8{32'h22}}, 16'd1);
    expect_txn(32'h33, 4'b1000, 1'b0, {8{32'h33}}, 16'd1);
    req_key_req[2] = 1'b1;
    wait_mreq(20, "drain_first_grant");
    req_key_req[3] = 1'b1;
    run_until_empty(100, "drain_hold");
    chk("drain_hold_gap", 32'(mreq_rise_cyc - ack_cyc[2]), 32'd7);
    hold_cfg[2] = 0;

    // reset during REQ drops the request at once; requester 0 goes first afterwards
    mem_delay = -1;
    req_key_id[63:32] = 32'h11;
    id_q.push_back(32'h11);
    req_key_req[1] = 1'b1;
    wait_mreq(20, "reset_mid_grant");
    repeat (3) cyc();
    #1 key_aresetn = 1'b0;
    #1;
    chk("rst_mid_mem_key_req", mem_key_req, 0);
    chk("rst_mid_req_key_ack", req_key_ack, 0);
    chk("rst_mid_timeout_count", timeout_count, 0);
    req_key_req = '0;
    repeat (2) cyc();
    mem_delay = 2; key_from_id = 1'b1;
    req_key_id[31:0]  = 32'h40;
    req_key_id[95:64] = 32'h42;
    expect_txn(32'h40, 4'b0001, 1'b0, {8{32'h40}}, 16'd0);
    expect_txn(32'h42, 4'b0100, 1'b0, {8{32'h42}}, 16'd0);
    req_key_req = 4'b0101;
    key_aresetn = 1'b1;
    run_until_empty(100, "post_reset_order");

    chk("resp_queue_drained", 256'(resp_q.size()), 256'd0);
    chk("id_queue_drained", 256'(id_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
